// File: rtl/fetch_unit_pkg.sv
// Shared front-end definitions for the fetch stage.
//   XLEN           : instruction and PC width
//   FETCH_RESET_PC : default first fetch address after reset
//   fetch_state_t  : fetch FSM state encoding (2 bits)
package fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h1c00_0000;

    // IDLE : one-cycle pause after reset
    // REQ  : presenting (or about to present) a request to the ICache
    // WAIT : one request outstanding, its packet is wanted
    // DROP : one request outstanding, its packet belongs to a dead path
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: holds the fetch pc and chooses its next value.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pc <= RESET_PC)
//   load_redirect : load redirect_pc (highest priority after reset)
//   redirect_pc   : new fetch pc on a redirect
//   advance       : a packet was consumed; step pc by +8 (aligned) or +4
//   pc            : current fetch pc
//   pc_plus4      : pc + 4, the address of the second slot
//   fetch_addr    : 8-byte aligned ICache request address
//   aligned       : pc sits at the start of an 8-byte packet
module fetch_pc_gen
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] fetch_addr,
    output logic            aligned
);

    // Alignment decode: an aligned pc consumes both words of the packet,
    // an unaligned pc (pc[2]=1) only the upper word.
    always_comb begin
        aligned    = ~pc[2];
        pc_plus4   = pc + 32'd4;
        fetch_addr = {pc[XLEN-1:3], 3'b000};
    end

    // Next-pc mux. Arithmetic wraps modulo 2^32 by construction.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load_redirect) begin
            pc <= redirect_pc;
        end else if (advance) begin
            pc <= aligned ? (pc + 32'd8) : pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one 8-byte ICache request at a time and
// delivers up to two instructions per packet to the instruction buffer.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   redirect_en, redirect_pc  : branch/exception redirect to a new pc
//   buf_ready                 : buffer can take two more instructions
//   icache_req_valid/addr     : request to the ICache (addr 8-byte aligned)
//   icache_req_ready          : ICache accepts the request
//   icache_resp_valid/word0/1 : returned packet, word0 at addr, word1 at addr+4
//   inst_1_o, pc_1_o          : first delivered instruction and its pc
//   inst_2_o, pc_2_o          : second delivered instruction and its pc
//   is_inst1_valid/2_valid    : single-cycle write enables into the buffer
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            buf_ready,
    output logic            icache_req_valid,
    output logic [XLEN-1:0] icache_req_addr,
    input  logic            icache_req_ready,
    input  logic            icache_resp_valid,
    input  logic [XLEN-1:0] icache_resp_word0,
    input  logic [XLEN-1:0] icache_resp_word1,
    output logic [XLEN-1:0] inst_1_o,
    output logic [XLEN-1:0] inst_2_o,
    output logic [XLEN-1:0] pc_1_o,
    output logic [XLEN-1:0] pc_2_o,
    output logic            is_inst1_valid,
    output logic            is_inst2_valid
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic            req_shown_q;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] fetch_addr;
    logic            aligned;
    logic            handshake;
    logic            resp_accept;

    fetch_pc_gen #(
        .RESET_PC(RESET_PC)
    ) u_pc_gen (
        .clk          (clk),
        .rst          (rst),
        .load_redirect(redirect_en),
        .redirect_pc  (redirect_pc),
        .advance      (resp_accept),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_addr   (fetch_addr),
        .aligned      (aligned)
    );

    // Request side. buf_ready only gates the start of a request; once the
    // request has been shown it is held until the ICache takes it, so the
    // ICache never sees valid drop without a handshake. A packet is used only
    // in WAIT and only when no redirect arrives in the same cycle.
    always_comb begin
        icache_req_valid = !rst && (state_q == ST_REQ) && (buf_ready || req_shown_q);
        icache_req_addr  = fetch_addr;
        handshake        = icache_req_valid && icache_req_ready;
        resp_accept      = (state_q == ST_WAIT) && icache_resp_valid && !redirect_en;
    end

    // Next-state logic. Redirect beats a response everywhere. A redirect in
    // DROP that meets the awaited response consumes that response and goes
    // to REQ; staying in DROP there would wait for a packet that never comes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (handshake) begin
                    state_d = redirect_en ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_en) begin
                    state_d = icache_resp_valid ? ST_REQ : ST_DROP;
                end else if (icache_resp_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (icache_resp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register plus the "request already shown" flag used to keep the
    // request stable while the ICache stalls. A redirect abandons the shown
    // request, so the flag is dropped with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_shown_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (redirect_en || handshake) begin
                req_shown_q <= 1'b0;
            end else if (icache_req_valid) begin
                req_shown_q <= 1'b1;
            end
        end
    end

    // Output registers: a used packet shows up one cycle later as a one-cycle
    // pulse; every other cycle the slots drive all zeros.
    always_ff @(posedge clk) begin
        if (rst || !resp_accept) begin
            is_inst1_valid <= 1'b0;
            is_inst2_valid <= 1'b0;
            inst_1_o       <= '0;
            inst_2_o       <= '0;
            pc_1_o         <= '0;
            pc_2_o         <= '0;
        end else begin
            is_inst1_valid <= 1'b1;
            is_inst2_valid <= aligned;
            inst_1_o       <= aligned ? icache_resp_word0 : icache_resp_word1;
            inst_2_o       <= aligned ? icache_resp_word1 : '0;
            pc_1_o         <= pc;
            pc_2_o         <= aligned ? pc_plus4 : '0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios pinned with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (current pc, one outstanding request, dead-path flag).
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        buf_ready;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_word0;
    logic [31:0] icache_resp_word1;
    logic [31:0] inst_1_o, inst_2_o, pc_1_o, pc_2_o;
    logic        is_inst1_valid, is_inst2_valid;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_en      (redirect_en),
        .redirect_pc      (redirect_pc),
        .buf_ready        (buf_ready),
        .icache_req_valid (icache_req_valid),
        .icache_req_addr  (icache_req_addr),
        .icache_req_ready (icache_req_ready),
        .icache_resp_valid(icache_resp_valid),
        .icache_resp_word0(icache_resp_word0),
        .icache_resp_word1(icache_resp_word1),
        .inst_1_o         (inst_1_o),
        .inst_2_o         (inst_2_o),
        .pc_1_o           (pc_1_o),
        .pc_2_o           (pc_2_o),
        .is_inst1_valid   (is_inst1_valid),
        .is_inst2_valid   (is_inst2_valid)
    );

    int total = 0;
    int bad   = 0;

    // stimulus controls (redirect and spurious response are one-shot)
    bit          drv_rst, drv_redir, drv_buf, drv_rdy, drv_spur, dir_words;
    logic [31:0] drv_rpc;
    int          lat_cfg;

    // ICache responder
    bit          ic_pend;
    int          ic_cnt;
    logic [31:0] ic_addr;

    // reference model
    logic [31:0] m_pc;
    bit          m_busy, m_stale, m_idle, m_held;
    logic        ev1, ev2;
    logic [31:0] ei1, ei2, ep1, ep2;
    bit          prev_redir;

    // observations for the literal checks
    bit          hs_seen;
    logic        last_req_valid;
    logic [31:0] last_req_addr;
    logic [31:0] hs_log[$];
    logic [31:0] out_pc1[$];
    logic [31:0] out_inst1[$];
    logic [31:0] out_pc2[$];
    logic        out_v2[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearLogs();
        hs_log.delete();
        out_pc1.delete();
        out_inst1.delete();
        out_pc2.delete();
        out_v2.delete();
    endtask

    // Registered outputs against what the model predicted last cycle.
    task automatic compareCycle();
        checkOutput("is_inst1_valid", is_inst1_valid, ev1);
        checkOutput("is_inst2_valid", is_inst2_valid, ev2);
        checkOutput("inst_1_o", inst_1_o, ei1);
        checkOutput("inst_2_o", inst_2_o, ei2);
        checkOutput("pc_1_o", pc_1_o, ep1);
        checkOutput("pc_2_o", pc_2_o, ep2);
        if (prev_redir) checkOutput("valids_after_redirect", {is_inst1_valid, is_inst2_valid}, 0);
        if (is_inst1_valid === 1'b1) begin
            out_pc1.push_back(pc_1_o);
            out_inst1.push_back(inst_1_o);
            out_pc2.push_back(pc_2_o);
            out_v2.push_back(is_inst2_valid);
        end
    endtask

    task automatic applyStimulus();
        rst               = drv_rst;
        redirect_en       = drv_redir;
        redirect_pc       = drv_rpc;
        buf_ready         = drv_buf;
        icache_req_ready  = drv_rdy;
        icache_resp_valid = 1'b0;
        icache_resp_word0 = $urandom();
        icache_resp_word1 = $urandom();
        if (ic_pend) begin
            ic_cnt--;
            if (ic_cnt == 0) begin
                icache_resp_valid = 1'b1;
                ic_pend           = 1'b0;
                if (dir_words) begin
                    icache_resp_word0 = ~ic_addr;
                    icache_resp_word1 = ~(ic_addr + 32'd4);
                end
            end
        end
        if (drv_spur) icache_resp_valid = 1'b1;
        drv_redir = 1'b0;
        drv_spur  = 1'b0;
    endtask

    // Transaction-level view: a request may go out only when nothing is
    // outstanding; a packet is used only if its path is still current and no
    // redirect arrives with it; a redirect retargets pc and kills the
    // outstanding packet.
    task automatic modelStep();
        bit exp_rv;
        bit hs;
        hs_seen        = 1'b0;
        last_req_valid = icache_req_valid;
        last_req_addr  = icache_req_addr;
        prev_redir     = redirect_en;
        ev1 = 1'b0; ev2 = 1'b0; ei1 = '0; ei2 = '0; ep1 = '0; ep2 = '0;
        if (rst) begin
            checkOutput("req_valid_in_reset", icache_req_valid, 0);
            m_pc    = RST_PC;
            m_busy  = 1'b0;
            m_stale = 1'b0;
            m_idle  = 1'b1;
            m_held  = 1'b0;
            ic_pend = 1'b0;
        end else begin
            exp_rv = !m_busy && !m_idle && (buf_ready || m_held);
            hs     = exp_rv && icache_req_ready;
            checkOutput("icache_req_valid", icache_req_valid, exp_rv);
            if (exp_rv) checkOutput("icache_req_addr", icache_req_addr, {m_pc[31:3], 3'b000});
            if (m_busy && icache_resp_valid) begin
                if (!m_stale && !redirect_en) begin
                    ev1 = 1'b1;
                    ep1 = m_pc;
                    if (m_pc[2]) begin
                        ei1  = icache_resp_word1;
                        m_pc = m_pc + 32'd4;
                    end else begin
                        ei1  = icache_resp_word0;
                        ev2  = 1'b1;
                        ei2  = icache_resp_word1;
                        ep2  = m_pc + 32'd4;
                        m_pc = m_pc + 32'd8;
                    end
                end
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end
            if (hs) begin
                m_busy  = 1'b1;
                m_stale = 1'b0;
                hs_seen = 1'b1;
                hs_log.push_back(icache_req_addr);
                ic_pend = 1'b1;
                ic_cnt  = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
                ic_addr = icache_req_addr;
            end
            if (redirect_en) begin
                m_pc = redirect_pc;
                if (m_busy) m_stale = 1'b1;
            end
            m_held = exp_rv && !hs && !redirect_en;
            m_idle = 1'b0;
        end
    endtask

    task automatic runCycle();
        @(posedge clk);
        #1;
        compareCycle();
        applyStimulus();
        #1;
        modelStep();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) runCycle();
    endtask

    task automatic waitHs(input int limit);
        int n;
        n = 0;
        do begin
            runCycle();
            n++;
        end while (!hs_seen && n < limit);
        checkOutput("handshake_timeout", hs_seen, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] r;
        drv_rst = 1'b1; drv_redir = 1'b0; drv_rpc = '0; drv_buf = 1'b1; drv_rdy = 1'b1;
        drv_spur = 1'b0; dir_words = 1'b1; lat_cfg = 1;
        ic_pend = 1'b0; ic_cnt = 0; ic_addr = '0;
        m_pc = RST_PC; m_busy = 1'b0; m_stale = 1'b0; m_idle = 1'b1; m_held = 1'b0;
        ev1 = 1'b0; ev2 = 1'b0; ei1 = '0; ei2 = '0; ep1 = '0; ep2 = '0; prev_redir = 1'b0;
        applyStimulus();

        // reset with a competing redirect; reset must win
        drv_redir = 1'b1; drv_rpc = 32'h0000_1000;
        runCycle();
        runCycle();
        checkOutput("reset_valids", {is_inst1_valid, is_inst2_valid}, 0);
        checkOutput("reset_pc_1_o", pc_1_o, 0);
        checkOutput("reset_inst_1_o", inst_1_o, 0);

        // release; a stray response in the first cycle must be ignored
        drv_rst = 1'b0; drv_spur = 1'b1;
        clearLogs();
        runCycle();
        checkOutput("idle_no_req", last_req_valid, 0);
        runCycles(8);
        checkOutput("first_req_addr", (hs_log.size() > 0) ? hs_log[0] : 'x, 32'h1c00_0000);
        checkOutput("second_req_addr", (hs_log.size() > 1) ? hs_log[1] : 'x, 32'h1c00_0008);
        checkOutput("first_pc_1", (out_pc1.size() > 0) ? out_pc1[0] : 'x, 32'h1c00_0000);
        checkOutput("first_pc_2", (out_pc2.size() > 0) ? out_pc2[0] : 'x, 32'h1c00_0004);
        checkOutput("first_inst_1", (out_inst1.size() > 0) ? out_inst1[0] : 'x, 32'he3ff_ffff);

        // redirect to an unaligned pc
        drv_redir = 1'b1; drv_rpc = 32'h1c00_0104;
        runCycle();
        clearLogs();
        runCycles(10);
        checkOutput("unal_req_addr", (hs_log.size() > 0) ? hs_log[0] : 'x, 32'h1c00_0100);
        checkOutput("unal_slot2", (out_v2.size() > 0) ? out_v2[0] : 'x, 0);
        checkOutput("unal_pc_1", (out_pc1.size() > 0) ? out_pc1[0] : 'x, 32'h1c00_0104);
        checkOutput("unal_inst_1", (out_inst1.size() > 0) ? out_inst1[0] : 'x, 32'he3ff_fefb);
        checkOutput("unal_next_addr", (hs_log.size() > 1) ? hs_log[1] : 'x, 32'h1c00_0108);

        // redirect while waiting; the late response is dropped
        lat_cfg = 4;
        waitHs(20);
        drv_redir = 1'b1; drv_rpc = 32'h1c00_0200;
        runCycle();
        clearLogs();
        lat_cfg = 1;
        runCycles(12);
        checkOutput("wait_redir_addr", (hs_log.size() > 0) ? hs_log[0] : 'x, 32'h1c00_0200);
        checkOutput("wait_redir_pc_1", (out_pc1.size() > 0) ? out_pc1[0] : 'x, 32'h1c00_0200);

        // redirect coincident with a response
        lat_cfg = 2;
        waitHs(20);
        runCycle();
        drv_redir = 1'b1; drv_rpc = 32'h1c00_0300;
        runCycle();
        checkOutput("coinc_resp_present", icache_resp_valid, 1);
        runCycle();
        checkOutput("coinc_no_pulse", is_inst1_valid, 0);
        checkOutput("coinc_req_valid", last_req_valid, 1);
        checkOutput("coinc_req_addr", last_req_addr, 32'h1c00_0300);

        // buffer full: no request until it drains
        drv_buf = 1'b0; drv_redir = 1'b1; drv_rpc = 32'h1c00_0400;
        lat_cfg = 1;
        runCycle();
        runCycles(3);
        for (int i = 0; i < 5; i++) begin
            runCycle();
            checkOutput("buffull_no_req", last_req_valid, 0);
        end
        drv_buf = 1'b1; drv_rdy = 1'b0;
        runCycle();
        checkOutput("resume_req_valid", last_req_valid, 1);
        checkOutput("resume_req_addr", last_req_addr, 32'h1c00_0400);

        // ICache stall: request held even if the buffer fills meanwhile
        drv_buf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            runCycle();
            checkOutput("stall_req_valid", last_req_valid, 1);
            checkOutput("stall_req_addr", last_req_addr, 32'h1c00_0400);
        end
        drv_rdy = 1'b1; drv_buf = 1'b1; lat_cfg = 5;
        runCycle();
        checkOutput("stall_handshake", hs_seen, 1);
        runCycle();
        drv_rst = 1'b1;
        runCycle();
        drv_rst = 1'b0; lat_cfg = 1;
        clearLogs();
        runCycles(8);
        checkOutput("midreset_req_addr", (hs_log.size() > 0) ? hs_log[0] : 'x, 32'h1c00_0000);
        checkOutput("midreset_pc_1", (out_pc1.size() > 0) ? out_pc1[0] : 'x, 32'h1c00_0000);

        // pc wrap at the top of the address space
        drv_redir = 1'b1; drv_rpc = 32'hffff_fff8;
        runCycle();
        clearLogs();
        runCycles(10);
        checkOutput("wrap_addr0", (hs_log.size() > 0) ? hs_log[0] : 'x, 32'hffff_fff8);
        checkOutput("wrap_addr1", (hs_log.size() > 1) ? hs_log[1] : 'x, 32'h0000_0000);
        checkOutput("wrap_pc_2", (out_pc2.size() > 0) ? out_pc2[0] : 'x, 32'hffff_fffc);

        // randomized traffic
        dir_words = 1'b0; lat_cfg = 0;
        for (int i = 0; i < 4000; i++) begin
            drv_rst   = ($urandom_range(0, 299) == 0);
            drv_redir = ($urandom_range(0, 9) == 0);
            r = $urandom();
            case ($urandom_range(0, 7))
                0:       drv_rpc = 32'hffff_fff8;
                1:       drv_rpc = 32'hffff_fffc;
                default: drv_rpc = {r[31:2], 2'b00};
            endcase
            drv_buf = ($urandom_range(0, 3) != 0);
            drv_rdy = ($urandom_range(0, 9) < 7);
            runCycle();
        end
        drv_rst = 1'b0; drv_redir = 1'b0;
        runCycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
